board_write_arbiter: RTL and testbench

Sequences every write into the board memory array (memArray) and shares its single write port between player 1, player 2 and a board-clear sequencer.
- Owns addr/cellState into memArray.
- Enforces turn order and rejects illegal moves (occupied cell, address > 8, game locked).
- Replaces ad-hoc address walking for board initialisation.
- Sits between gameController-level input handling and memArray; reads back gBoard for occupancy checks.

---
 rtl/board_write_arbiter_pkg.sv | 21 ++
 rtl/board_write_arbiter_cell_occupancy_mux.sv | 29 ++
 rtl/board_write_arbiter.sv | 158 +++++++++++++++
 tb/tb_board_write_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_write_arbiter_pkg.sv
// Shared types and constants for the tic-tac-toe board datapath.
// Cell encodings, arbiter states and board geometry live here.
package gamePkg;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      X     = 2'b10,
      O     = 2'b11
   } cellStateType;

   typedef enum logic [1:0] {
      CLEAR,
      IDLE,
      WRITE,
      SETTLE
   } arbStateType;

   localparam int         NUM_CELLS = 9;
   localparam logic [3:0] IDLE_ADDR = 4'b1111;

endpackage

// File: rtl/board_write_arbiter_cell_occupancy_mux.sv
// Combinational lookup of one board cell from the packed gBoard vector.
// Out-of-range addresses read back as EMPTY with inRange low.
module cell_occupancy_mux
   import gamePkg::*;
(
   input  logic [2*NUM_CELLS-1:0] gBoard,
   input  logic [3:0]             cellAddr,
   output logic [1:0]             cellValue,
   output logic                   inRange
);

   logic [1:0] cells [NUM_CELLS];

   for (genvar gi = 0; gi < NUM_CELLS; gi++) begin : g_cells
      assign cells[gi] = gBoard[2*gi +: 2];
   end

   always_comb begin
      cellValue = EMPTY;
      for (int i = 0; i < NUM_CELLS; i++) begin
         if (cellAddr == 4'(i)) begin
            cellValue = cells[i];
         end
      end
   end

   assign inRange = (cellAddr < 4'(NUM_CELLS));

endmodule

// File: rtl/board_write_arbiter.sv
// Single write port arbiter for memArray: board clear sequencer plus
// turn-ordered, legality-checked player moves. All outputs are registered.
module board_write_arbiter
   import gamePkg::*;
#(
   parameter logic [1:0] P1_MARK    = X,
   parameter logic [1:0] P2_MARK    = O,
   parameter logic [1:0] EMPTY_MARK = EMPTY
) (
   input  logic                   ph1,
   input  logic                   reset,
   input  logic                   clearReq,
   input  logic                   startP1,
   input  logic                   lockIn,
   input  logic                   p1Req,
   input  logic [3:0]             p1Addr,
   input  logic                   p2Req,
   input  logic [3:0]             p2Addr,
   input  logic [2*NUM_CELLS-1:0] gBoard,
   output logic [3:0]             addr,
   output logic [1:0]             cellState,
   output logic                   p1Ack,
   output logic                   p2Ack,
   output logic                   p1Nack,
   output logic                   p2Nack,
   output logic                   busy,
   output logic                   clearDone,
   output logic                   turnIsP1
);

   arbStateType state_q, state_d;
   logic [3:0]  count_q, count_d;
   logic [3:0]  addr_q, addr_d;
   logic [1:0]  cellState_q, cellState_d;
   logic        p1Ack_q, p1Ack_d, p2Ack_q, p2Ack_d;
   logic        p1Nack_q, p1Nack_d, p2Nack_q, p2Nack_d;
   logic        busy_q, busy_d, clearDone_q, clearDone_d;
   logic        turnIsP1_q, turnIsP1_d;

   logic        own_req, other_req;
   logic [3:0]  own_addr;
   logic [1:0]  own_cell;
   logic        own_in_range;

   assign own_req   = turnIsP1_q ? p1Req  : p2Req;
   assign other_req = turnIsP1_q ? p2Req  : p1Req;
   assign own_addr  = turnIsP1_q ? p1Addr : p2Addr;

   cell_occupancy_mux u_occ (
      .gBoard    (gBoard),
      .cellAddr  (own_addr),
      .cellValue (own_cell),
      .inRange   (own_in_range)
   );

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      addr_d      = IDLE_ADDR;
      cellState_d = EMPTY_MARK;
      p1Ack_d     = 1'b0;
      p2Ack_d     = 1'b0;
      p1Nack_d    = 1'b0;
      p2Nack_d    = 1'b0;
      clearDone_d = 1'b0;
      turnIsP1_d  = turnIsP1_q;
      case (state_q)
         CLEAR: begin
            if (clearReq) begin
               count_d = 4'd0;
            end else if (count_q < 4'(NUM_CELLS)) begin
               addr_d  = count_q;
               count_d = count_q + 4'd1;
            end else begin
               clearDone_d = 1'b1;
               turnIsP1_d  = startP1;
               state_d     = IDLE;
            end
         end
         IDLE: begin
            if (clearReq) begin
               state_d = CLEAR;
               count_d = 4'd0;
            end else begin
               // The non-turn player is always refused, whatever the owner does.
               if (other_req) begin
                  p1Nack_d = ~turnIsP1_q;
                  p2Nack_d = turnIsP1_q;
               end
               if (own_req) begin
                  if (lockIn || !own_in_range || own_cell != EMPTY_MARK) begin
                     p1Nack_d = p1Nack_d | turnIsP1_q;
                     p2Nack_d = p2Nack_d | ~turnIsP1_q;
                  end else begin
                     state_d     = WRITE;
                     addr_d      = own_addr;
                     cellState_d = turnIsP1_q ? P1_MARK : P2_MARK;
                  end
               end
            end
         end
         WRITE: begin
            // Only the turn owner ever reaches WRITE, so the turn names the writer.
            state_d    = SETTLE;
            p1Ack_d    = turnIsP1_q;
            p2Ack_d    = ~turnIsP1_q;
            turnIsP1_d = ~turnIsP1_q;
         end
         SETTLE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = CLEAR;
            count_d = 4'd0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge ph1) begin
      if (reset) begin
         state_q     <= CLEAR;
         count_q     <= 4'd0;
         addr_q      <= IDLE_ADDR;
         cellState_q <= EMPTY_MARK;
         p1Ack_q     <= 1'b0;
         p2Ack_q     <= 1'b0;
         p1Nack_q    <= 1'b0;
         p2Nack_q    <= 1'b0;
         busy_q      <= 1'b1;
         clearDone_q <= 1'b0;
         turnIsP1_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         addr_q      <= addr_d;
         cellState_q <= cellState_d;
         p1Ack_q     <= p1Ack_d;
         p2Ack_q     <= p2Ack_d;
         p1Nack_q    <= p1Nack_d;
         p2Nack_q    <= p2Nack_d;
         busy_q      <= busy_d;
         clearDone_q <= clearDone_d;
         turnIsP1_q  <= turnIsP1_d;
      end
   end

   assign addr      = addr_q;
   assign cellState = cellState_q;
   assign p1Ack     = p1Ack_q;
   assign p2Ack     = p2Ack_q;
   assign p1Nack    = p1Nack_q;
   assign p2Nack    = p2Nack_q;
   assign busy      = busy_q;
   assign clearDone = clearDone_q;
   assign turnIsP1  = turnIsP1_q;

endmodule

// File: tb/tb_board_write_arbiter.sv
// Scoreboard bench for board_write_arbiter with a behavioural memArray model
// feeding gBoard; expected writes/acks/nacks are queued with their cycle.
module tb_board_write_arbiter;

   localparam int K_WR     = 0;
   localparam int K_P1ACK  = 1;
   localparam int K_P2ACK  = 2;
   localparam int K_P1NACK = 3;
   localparam int K_P2NACK = 4;
   localparam int K_CDONE  = 5;

   typedef struct {
      int         cyc;
      int         kind;
      logic [3:0] a;
      logic [1:0] v;
   } ev_t;

   ev_t exp_q[$];

   logic        ph1 = 1'b0;
   logic        reset = 1'b1;
   logic        clearReq = 1'b0;
   logic        startP1 = 1'b1;
   logic        lockIn = 1'b0;
   logic        p1Req = 1'b0;
   logic [3:0]  p1Addr = 4'd0;
   logic        p2Req = 1'b0;
   logic [3:0]  p2Addr = 4'd0;
   logic [17:0] gBoard;
   logic [3:0]  addr;
   logic [1:0]  cellState;
   logic        p1Ack, p2Ack, p1Nack, p2Nack, busy, clearDone, turnIsP1;

   logic [1:0]  mem [9];
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   bit          mon_en = 1'b0;

   board_write_arbiter dut (
      .ph1       (ph1),
      .reset     (reset),
      .clearReq  (clearReq),
      .startP1   (startP1),
      .lockIn    (lockIn),
      .p1Req     (p1Req),
      .p1Addr    (p1Addr),
      .p2Req     (p2Req),
      .p2Addr    (p2Addr),
      .gBoard    (gBoard),
      .addr      (addr),
      .cellState (cellState),
      .p1Ack     (p1Ack),
      .p2Ack     (p2Ack),
      .p1Nack    (p1Nack),
      .p2Nack    (p2Nack),
      .busy      (busy),
      .clearDone (clearDone),
      .turnIsP1  (turnIsP1)
   );

   always #5 ph1 = ~ph1;

   always @(posedge ph1) cyc <= cyc + 1;

   // memArray model: stale non-empty contents until the first clear lands
   always @(posedge ph1) begin
      if (cyc == 0) begin
         for (int i = 0; i < 9; i++) mem[i] <= 2'b01;
      end else if (addr < 4'd9) begin
         mem[addr] <= cellState;
      end
   end

   for (genvar gi = 0; gi < 9; gi++) begin : g_board
      assign gBoard[2*gi +: 2] = mem[gi];
   end

   function automatic string kname(int k);
      case (k)
         K_WR:     return "write";
         K_P1ACK:  return "p1Ack";
         K_P2ACK:  return "p2Ack";
         K_P1NACK: return "p1Nack";
         K_P2NACK: return "p2Nack";
         default:  return "clearDone";
      endcase
   endfunction

   function automatic void push(int c, int k, logic [3:0] a, logic [1:0] v);
      ev_t e;
      e.cyc = c; e.kind = k; e.a = a; e.v = v;
      exp_q.push_back(e);
   endfunction

   function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   function automatic void observe(int k, logic [3:0] a, logic [1:0] v);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_%s: got addr=%0h val=%0h at cycle %0d, required no event",
                  kname(k), a, v, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.cyc != cyc || e.a !== a || e.v !== v) begin
            failures++;
            $display("FAIL event_%s: got %s addr=%0h val=%0h cycle %0d, required %s addr=%0h val=%0h cycle %0d",
                     kname(e.kind), kname(k), a, v, cyc, kname(e.kind), e.a, e.v, e.cyc);
         end
      end
   endfunction

   // Monitor: every write/ack/nack/clearDone the DUT presents must match the queue head
   always @(negedge ph1) begin
      if (mon_en) begin
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL missed_%s: got nothing by cycle %0d, required addr=%0h val=%0h at cycle %0d",
                     kname(exp_q[0].kind), cyc, exp_q[0].a, exp_q[0].v, exp_q[0].cyc);
            void'(exp_q.pop_front());
         end
         if (addr !== 4'hF)    observe(K_WR, addr, cellState);
         if (p1Ack !== 1'b0)   observe(K_P1ACK, 4'd0, 2'd0);
         if (p2Ack !== 1'b0)   observe(K_P2ACK, 4'd0, 2'd0);
         if (p1Nack !== 1'b0)  observe(K_P1NACK, 4'd0, 2'd0);
         if (p2Nack !== 1'b0)  observe(K_P2NACK, 4'd0, 2'd0);
         if (clearDone !== 1'b0) observe(K_CDONE, 4'd0, 2'd0);
      end
   end

   task automatic req(input bit r1, input logic [3:0] a1, input bit r2,
                      input logic [3:0] a2, input bit clr);
      p1Req = r1; p1Addr = a1; p2Req = r2; p2Addr = a2; clearReq = clr;
      @(negedge ph1);
      p1Req = 1'b0; p2Req = 1'b0; clearReq = 1'b0;
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) @(negedge ph1);
   endtask

   task automatic expect_clear(input int s);
      for (int i = 0; i < 9; i++) push(s + i, K_WR, 4'(i), 2'b00);
      push(s + 9, K_CDONE, 4'd0, 2'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish by time %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t;
      repeat (2) @(negedge ph1);
      chk("reset_addr", addr, 4'hF);
      chk("reset_cellState", cellState, 2'b00);
      chk("reset_busy", busy, 1'b1);
      chk("reset_turn", turnIsP1, 1'b1);
      chk("reset_pulses", {p1Ack, p2Ack, p1Nack, p2Nack, clearDone}, 5'b0);

      // Initial clear after reset release
      mon_en = 1'b1;
      t = cyc;
      reset = 1'b0;
      expect_clear(t + 1);
      wait_to(t + 10);
      chk("clear_busy", busy, 1'b0);
      chk("clear_turn", turnIsP1, 1'b1);
      chk("clear_board", gBoard, 18'h0);

      // P1 legal move to cell 0
      t = cyc;
      push(t + 1, K_WR, 4'd0, 2'b10);
      push(t + 2, K_P1ACK, 4'd0, 2'd0);
      req(1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
      wait_to(t + 3);
      chk("p1_move_turn", turnIsP1, 1'b0);
      chk("p1_move_busy", busy, 1'b0);
      chk("p1_move_board", gBoard, 18'h00002);

      // P1 out of turn, then P2 onto occupied cell 0
      t = cyc;
      push(t + 1, K_P1NACK, 4'd0, 2'd0);
      req(1'b1, 4'd1, 1'b0, 4'd0, 1'b0);
      push(t + 2, K_P2NACK, 4'd0, 2'd0);
      req(1'b0, 4'd0, 1'b1, 4'd0, 1'b0);
      wait_to(t + 3);
      chk("nack_turn", turnIsP1, 1'b0);
      chk("nack_board", gBoard, 18'h00002);

      // P2 out of range address 9, then legal cell 4
      t = cyc;
      push(t + 1, K_P2NACK, 4'd0, 2'd0);
      req(1'b0, 4'd0, 1'b1, 4'd9, 1'b0);
      push(t + 2, K_WR, 4'd4, 2'b11);
      push(t + 3, K_P2ACK, 4'd0, 2'd0);
      req(1'b0, 4'd0, 1'b1, 4'd4, 1'b0);
      wait_to(t + 4);
      chk("p2_move_board", gBoard, 18'h00302);
      chk("p2_move_turn", turnIsP1, 1'b1);

      // clearReq wins over a same-cycle move; request while busy is dropped
      t = cyc;
      expect_clear(t + 2);
      req(1'b1, 4'd2, 1'b0, 4'd0, 1'b1);
      chk("clear_busy_high", busy, 1'b1);
      req(1'b1, 4'd3, 1'b0, 4'd0, 1'b0);
      wait_to(t + 11);
      chk("reclear_board", gBoard, 18'h0);
      chk("reclear_busy", busy, 1'b0);
      chk("reclear_turn", turnIsP1, 1'b1);

      // Locked game, then simultaneous requests with P1 owning the turn
      t = cyc;
      lockIn = 1'b1;
      push(t + 1, K_P1NACK, 4'd0, 2'd0);
      req(1'b1, 4'd5, 1'b0, 4'd0, 1'b0);
      lockIn = 1'b0;
      chk("lock_turn", turnIsP1, 1'b1);
      push(t + 2, K_WR, 4'd5, 2'b10);
      push(t + 2, K_P2NACK, 4'd0, 2'd0);
      push(t + 3, K_P1ACK, 4'd0, 2'd0);
      req(1'b1, 4'd5, 1'b1, 4'd6, 1'b0);
      wait_to(t + 4);
      chk("both_turn", turnIsP1, 1'b0);
      chk("both_board", gBoard, 18'h00800);

      // P2 writes last cell; reset lands during WRITE and abandons it
      push(t + 5, K_WR, 4'd8, 2'b11);
      req(1'b0, 4'd0, 1'b1, 4'd8, 1'b0);
      reset = 1'b1;
      @(negedge ph1);
      chk("midreset_addr", addr, 4'hF);
      chk("midreset_busy", busy, 1'b1);
      chk("midreset_ack", p2Ack, 1'b0);
      chk("midreset_turn", turnIsP1, 1'b1);
      startP1 = 1'b0;
      reset = 1'b0;
      expect_clear(t + 7);
      wait_to(t + 16);
      chk("startp2_turn", turnIsP1, 1'b0);
      chk("startp2_board", gBoard, 18'h0);

      // P2 moves first after a clear with startP1=0
      t = cyc;
      push(t + 1, K_WR, 4'd0, 2'b11);
      push(t + 2, K_P2ACK, 4'd0, 2'd0);
      req(1'b0, 4'd0, 1'b1, 4'd0, 1'b0);
      wait_to(t + 3);
      chk("p2_first_turn", turnIsP1, 1'b1);
      chk("p2_first_board", gBoard, 18'h00003);

      repeat (3) @(negedge ph1);
      chk("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
